// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end.
// Holds the datapath widths, the fetch FSM state type, the reset PC and
// the position of the opcode field inside an instruction word.
package cpu_pkg;

    localparam int PC_WIDTH    = 9;
    localparam int INSTR_WIDTH = 16;
    localparam int BUS_WIDTH   = 8;

    localparam logic [PC_WIDTH-1:0] RESET_PC = '0;

    // Opcode occupies the top five bits of every instruction word.
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 11;
    localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_WIDTH-1:0] ir);
        return ir[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter register.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   load       : load pc from value (wins over inc)
//   inc        : increment pc, wrapping modulo 2^PC_WIDTH
//   value      : load value
//   pc         : current program counter
module program_counter
    import cpu_pkg::*;
#(
    parameter int                   PC_WIDTH = cpu_pkg::PC_WIDTH,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                inc,
    input  logic [PC_WIDTH-1:0] value,
    output logic [PC_WIDTH-1:0] pc
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= value;
        end else if (inc) begin
            // Natural overflow of the PC_WIDTH-bit add gives the wrap to 0.
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, reads words from the synchronous
// code memory and hands them to control_unit.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_fetch_req        : request the next instruction (ignored while busy)
//   in_pc_load          : load PC from in_pc_value; aborts an in-flight fetch
//   in_pc_inc           : skip one word (ignored while busy)
//   in_pc_value         : PC load value
//   in_pc_enable_out    : drive PC[7:0] on out_bus
//   in_ir_enable_read   : drive IR[7:0] on out_bus (wins over PC)
//   in_code_data        : code memory read data
//   out_code_addr       : registered code memory address
//   out_code_rd_en      : one-cycle read strobe per fetch
//   out_ir, out_ir_valid: instruction register and its fresh flag
//   out_pc              : current PC
//   out_busy            : fetch in flight (REQ or WAIT)
//   out_bus, out_bus_valid : combinational shared-bus drive
//
// Handshake: a fetch is accepted on a rising edge where the unit is idle,
// in_fetch_req is high and in_pc_load is low. out_ir_valid rises
// MEM_LATENCY+1 cycles later and stays high until the next accepted fetch.
// MEM_LATENCY must lie in 1..4.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                   PC_WIDTH    = cpu_pkg::PC_WIDTH,
    parameter int                   INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
    parameter int                   MEM_LATENCY = 1,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = cpu_pkg::RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_fetch_req,
    input  logic                   in_pc_load,
    input  logic                   in_pc_inc,
    input  logic [PC_WIDTH-1:0]    in_pc_value,
    input  logic                   in_pc_enable_out,
    input  logic                   in_ir_enable_read,
    input  logic [INSTR_WIDTH-1:0] in_code_data,
    output logic [PC_WIDTH-1:0]    out_code_addr,
    output logic                   out_code_rd_en,
    output logic [INSTR_WIDTH-1:0] out_ir,
    output logic                   out_ir_valid,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic                   out_busy,
    output logic [BUS_WIDTH-1:0]   out_bus,
    output logic                   out_bus_valid
);

    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    fetch_state_t              state_q, state_d;
    logic [2:0]                cnt_q, cnt_d;
    logic [PC_WIDTH-1:0]       addr_q, addr_d;
    logic                      rd_en_q, rd_en_d;
    logic [INSTR_WIDTH-1:0]    ir_q, ir_d;
    logic                      valid_q, valid_d;
    logic                      pc_ld, pc_in;
    logic [PC_WIDTH-1:0]       pc;

    program_counter #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pc_ld),
        .inc   (pc_in),
        .value (in_pc_value),
        .pc    (pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= RESET_PC;
            rd_en_q <= 1'b0;
            ir_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rd_en_q <= rd_en_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rd_en_d = 1'b0;
        ir_d    = ir_q;
        valid_d = valid_q;
        pc_ld   = 1'b0;
        pc_in   = 1'b0;

        case (state_q)
            IDLE: begin
                // A load in the same cycle as a request takes priority and
                // the request is dropped; control_unit re-issues it.
                if (in_pc_load) begin
                    pc_ld = 1'b1;
                end else if (in_fetch_req) begin
                    valid_d = 1'b0;
                    addr_d  = pc;
                    rd_en_d = 1'b1;
                    cnt_d   = LAT;
                    state_d = REQ;
                end else if (in_pc_inc) begin
                    pc_in = 1'b1;
                end
            end
            REQ: begin
                if (in_pc_load) begin
                    pc_ld   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Abort beats capture: the response is simply never latched.
                if (in_pc_load) begin
                    pc_ld   = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == 3'd0) begin
                    ir_d    = in_code_data;
                    valid_d = 1'b1;
                    pc_in   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign out_code_addr = addr_q;
    assign out_code_rd_en = rd_en_q;
    assign out_ir        = ir_q;
    assign out_ir_valid  = valid_q;
    assign out_pc        = pc;
    assign out_busy      = (state_q != IDLE);

    always_comb begin
        out_bus = '0;
        if (in_ir_enable_read) begin
            out_bus = ir_q[BUS_WIDTH-1:0];
        end else if (in_pc_enable_out) begin
            out_bus = pc[BUS_WIDTH-1:0];
        end
    end

    assign out_bus_valid = in_ir_enable_read | in_pc_enable_out;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req, pc_load, pc_inc, pc_en, ir_en;
    logic [8:0]  pc_value;

    logic [15:0] code_data [2] = '{default: 16'h0};
    logic [8:0]  code_addr [2];
    logic        rd_en     [2];
    logic [15:0] ir_o      [2];
    logic        valid_o   [2];
    logic [8:0]  pc_o      [2];
    logic        busy_o    [2];
    logic [7:0]  bus_o     [2];
    logic        bus_v_o   [2];

    logic [15:0] mem [512];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state, one set per instance
    int          m_pc    [2];
    int          m_ir    [2];
    bit          m_valid [2];
    bit          m_busy  [2];
    int          m_done  [2];
    int          m_faddr [2];
    int          m_addr  [2];
    bit          m_rden  [2];

    always #5 clk = ~clk;

    instruction_fetch_unit #(.MEM_LATENCY(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .in_fetch_req(fetch_req), .in_pc_load(pc_load),
        .in_pc_inc(pc_inc), .in_pc_value(pc_value), .in_pc_enable_out(pc_en),
        .in_ir_enable_read(ir_en), .in_code_data(code_data[0]),
        .out_code_addr(code_addr[0]), .out_code_rd_en(rd_en[0]), .out_ir(ir_o[0]),
        .out_ir_valid(valid_o[0]), .out_pc(pc_o[0]), .out_busy(busy_o[0]),
        .out_bus(bus_o[0]), .out_bus_valid(bus_v_o[0])
    );

    instruction_fetch_unit #(.MEM_LATENCY(3)) dut_l3 (
        .clk(clk), .rst_n(rst_n), .in_fetch_req(fetch_req), .in_pc_load(pc_load),
        .in_pc_inc(pc_inc), .in_pc_value(pc_value), .in_pc_enable_out(pc_en),
        .in_ir_enable_read(ir_en), .in_code_data(code_data[1]),
        .out_code_addr(code_addr[1]), .out_code_rd_en(rd_en[1]), .out_ir(ir_o[1]),
        .out_ir_valid(valid_o[1]), .out_pc(pc_o[1]), .out_busy(busy_o[1]),
        .out_bus(bus_o[1]), .out_bus_valid(bus_v_o[1])
    );

    // Synchronous code memories: data for a strobe sampled at edge N is
    // presented after edge N+L-1 ... i.e. valid L cycles after the strobe edge.
    always @(posedge clk) begin
        if (rd_en[0]) code_data[0] <= mem[code_addr[0]];
    end

    logic       sr_v [2] = '{default: 1'b0};
    logic [8:0] sr_a [2] = '{default: 9'h0};
    always @(posedge clk) begin
        sr_v[0] <= rd_en[1];
        sr_a[0] <= code_addr[1];
        sr_v[1] <= sr_v[0];
        sr_a[1] <= sr_a[0];
        if (sr_v[1]) code_data[1] <= mem[sr_a[1]];
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Advance the model by one rising edge using the inputs now applied.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit rden_next;
            rden_next = 1'b0;
            if (!rst_n) begin
                m_pc[k] = 0; m_ir[k] = 0; m_valid[k] = 1'b0; m_busy[k] = 1'b0;
                m_addr[k] = 0;
            end else if (m_busy[k]) begin
                if (pc_load) begin
                    m_pc[k]   = int'(pc_value);
                    m_busy[k] = 1'b0;
                end else if (cyc + 1 == m_done[k]) begin
                    m_ir[k]    = int'(mem[m_faddr[k]]);
                    m_valid[k] = 1'b1;
                    m_pc[k]    = (m_pc[k] + 1) % 512;
                    m_busy[k]  = 1'b0;
                end
            end else if (pc_load) begin
                m_pc[k] = int'(pc_value);
            end else if (fetch_req) begin
                m_valid[k] = 1'b0;
                m_faddr[k] = m_pc[k];
                m_addr[k]  = m_pc[k];
                m_busy[k]  = 1'b1;
                m_done[k]  = cyc + 1 + lat_of(k) + 1;
                rden_next  = 1'b1;
            end else if (pc_inc) begin
                m_pc[k] = (m_pc[k] + 1) % 512;
            end
            m_rden[k] = rden_next;
        end
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s L=%0d cyc=%0d observed=%h expected=%h", tag, lat_of(k), cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            int exp_bus;
            exp_bus = ir_en ? (m_ir[k] & 8'hFF) : (pc_en ? (m_pc[k] & 8'hFF) : 0);
            chk("pc",        k, 32'(pc_o[k]),      32'(m_pc[k]));
            chk("ir",        k, 32'(ir_o[k]),      32'(m_ir[k]));
            chk("ir_valid",  k, 32'(valid_o[k]),   32'(m_valid[k]));
            chk("busy",      k, 32'(busy_o[k]),    32'(m_busy[k]));
            chk("rd_en",     k, 32'(rd_en[k]),     32'(m_rden[k]));
            chk("code_addr", k, 32'(code_addr[k]), 32'(m_addr[k]));
            chk("bus",       k, 32'(bus_o[k]),     32'(exp_bus));
            chk("bus_valid", k, 32'(bus_v_o[k]),   32'(ir_en | pc_en));
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        cyc++;
        #1;
        check_all();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && (m_busy[0] || m_busy[1]); i++) tick();
    endtask

    task automatic fetch();
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
    endtask

    task automatic load(input logic [8:0] v);
        pc_load = 1'b1; pc_value = v;
        tick();
        pc_load = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
        mem[0]  = 16'b01001_011_11110000;
        rst_n = 1'b0; fetch_req = 1'b0; pc_load = 1'b0; pc_inc = 1'b0;
        pc_en = 1'b0; ir_en = 1'b0; pc_value = '0;
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 0; m_ir[k] = 0; m_valid[k] = 0; m_busy[k] = 0;
            m_done[k] = 0; m_faddr[k] = 0; m_addr[k] = 0; m_rden[k] = 0;
        end

        // Reset state
        tick(); tick();
        rst_n = 1'b1;

        // Reset then fetch from address 0
        fetch();
        chk("strobe_addr0", 0, 32'(code_addr[0]), 32'h0);
        chk("strobe_on", 0, 32'(rd_en[0]), 32'h1);
        tick();
        chk("strobe_off", 0, 32'(rd_en[0]), 32'h0);
        tick();
        chk("first_ir", 0, 32'(ir_o[0]), 32'h4BF0);
        chk("first_valid", 0, 32'(valid_o[0]), 32'h1);
        chk("first_pc", 0, 32'(pc_o[0]), 32'h1);
        wait_idle();
        chk("first_ir", 1, 32'(ir_o[1]), 32'h4BF0);

        // Jump then fetch
        load(9'h1F0);
        fetch();
        chk("jump_addr", 0, 32'(code_addr[0]), 32'h1F0);
        chk("jump_addr", 1, 32'(code_addr[1]), 32'h1F0);
        wait_idle();
        chk("jump_pc", 0, 32'(pc_o[0]), 32'h1F1);

        // Wrap on fetch and on increment
        load(9'h1FF);
        fetch();
        wait_idle();
        chk("wrap_fetch_pc", 1, 32'(pc_o[1]), 32'h0);
        chk("wrap_fetch_ir", 1, 32'(ir_o[1]), 32'(mem[511]));
        load(9'h1FF);
        pc_inc = 1'b1; tick(); pc_inc = 1'b0;
        chk("wrap_inc_pc", 0, 32'(pc_o[0]), 32'h0);

        // Abort while waiting, then fetch from the loaded address
        fetch();
        tick();
        load(9'h020);
        chk("abort_valid", 1, 32'(valid_o[1]), 32'h0);
        chk("abort_busy", 1, 32'(busy_o[1]), 32'h0);
        fetch();
        chk("abort_next_addr", 1, 32'(code_addr[1]), 32'h020);
        wait_idle();
        chk("abort_next_ir", 0, 32'(ir_o[0]), 32'(mem[32]));

        // Bus mux
        load(9'h000);
        fetch();
        wait_idle();
        load(9'h105);
        pc_en = 1'b1; #1;
        chk("bus_pc_only", 0, 32'(bus_o[0]), 32'h05);
        check_all();
        ir_en = 1'b1; #1;
        chk("bus_both", 0, 32'(bus_o[0]), 32'hF0);
        check_all();
        pc_en = 1'b0; ir_en = 1'b0; #1;
        chk("bus_none", 0, 32'(bus_o[0]), 32'h0);
        chk("bus_none_valid", 0, 32'(bus_v_o[0]), 32'h0);

        // Reset in the middle of a long-latency fetch
        fetch();
        tick(); tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("midrst_pc", 1, 32'(pc_o[1]), 32'h0);
        chk("midrst_ir", 1, 32'(ir_o[1]), 32'h0);
        chk("midrst_busy", 1, 32'(busy_o[1]), 32'h0);
        for (int i = 0; i < 6; i++) tick();
        chk("midrst_late_ir", 1, 32'(ir_o[1]), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            fetch_req = ($urandom_range(0, 2) != 0);
            pc_inc    = !fetch_req && ($urandom_range(0, 3) == 0);
            pc_load   = ($urandom_range(0, 9) == 0);
            pc_value  = 9'($urandom);
            pc_en     = 1'($urandom);
            ir_en     = 1'($urandom);
            rst_n     = ($urandom_range(0, 79) != 0);
            tick();
        end
        rst_n = 1'b1; fetch_req = 1'b0; pc_inc = 1'b0; pc_load = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
